// File: rtl/multibank_pingpong_ram_if.sv
// Writer/reader bus of the multibank ping-pong row buffer.
// The DUT takes the slave modport and the block driving writes/reads takes the master modport.
interface multibank_pingpong_ram_if #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 8,
  parameter int NUM_BANKS = 2
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int CW = $clog2(NUM_BANKS + 1);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DATA_W/8-1:0]   wr_be;
  logic [DATA_W-1:0]     wr_data;
  logic                  wr_commit;
  logic                  wr_ready;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic                  rd_release;
  logic                  rd_avail;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic [BW-1:0]         wr_bank;
  logic [BW-1:0]         rd_bank;
  logic [CW-1:0]         full_cnt;
  logic                  err;

  modport master (
    output wr_en, wr_addr, wr_be, wr_data, wr_commit, rd_en, rd_addr, rd_release,
    input  wr_ready, rd_avail, rd_data, rd_valid, wr_bank, rd_bank, full_cnt, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_be, wr_data, wr_commit, rd_en, rd_addr, rd_release,
    output wr_ready, rd_avail, rd_data, rd_valid, wr_bank, rd_bank, full_cnt, err
  );
endinterface

// File: rtl/multibank_pingpong_ram.sv
// N-bank circular row buffer: the writer fills and commits banks, the reader consumes
// committed banks in order and releases them. Read latency is 1 cycle, or 2 with OUT_REG.
module multibank_pingpong_ram #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 8,
  parameter int NUM_BANKS = 2,
  parameter int OUT_REG   = 1
) (
  input logic                    clk,
  input logic                    reset,
  multibank_pingpong_ram_if.slave bus
);
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int CW     = $clog2(NUM_BANKS + 1);
  localparam int NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem [NUM_BANKS][DEPTH];

  logic [BW-1:0]     wr_bank_q;
  logic [BW-1:0]     rd_bank_q;
  logic [CW-1:0]     full_q;
  logic              err_q;
  logic [DATA_W-1:0] rd_data_s1;
  logic              rd_valid_s1;

  logic wr_ready, rd_avail, wr_addr_ok, rd_addr_ok;
  logic wr_ok, rd_ok, commit_ok, release_ok, viol;

  assign wr_ready   = full_q < CW'(NUM_BANKS);
  assign rd_avail   = full_q != '0;
  assign wr_addr_ok = {1'b0, bus.wr_addr} < (AW+1)'(DEPTH);
  assign rd_addr_ok = {1'b0, bus.rd_addr} < (AW+1)'(DEPTH);

  assign wr_ok      = bus.wr_en & wr_ready & wr_addr_ok;
  assign rd_ok      = bus.rd_en & rd_avail & rd_addr_ok;
  assign commit_ok  = bus.wr_commit & wr_ready;
  assign release_ok = bus.rd_release & rd_avail;

  assign viol = ((bus.wr_en | bus.wr_commit) & ~wr_ready) |
                ((bus.rd_en | bus.rd_release) & ~rd_avail) |
                (bus.wr_en & ~wr_addr_ok) |
                (bus.rd_en & ~rd_addr_ok);

  // Explicit wrap so non-power-of-2 bank counts cycle correctly.
  function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
    return (b == BW'(NUM_BANKS - 1)) ? '0 : b + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (bus.wr_be[i]) mem[wr_bank_q][bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q   <= '0;
      rd_bank_q   <= '0;
      full_q      <= '0;
      err_q       <= 1'b0;
      rd_valid_s1 <= 1'b0;
      rd_data_s1  <= '0;
    end else begin
      if (commit_ok)  wr_bank_q <= next_bank(wr_bank_q);
      if (release_ok) rd_bank_q <= next_bank(rd_bank_q);
      case ({commit_ok, release_ok})
        2'b10:   full_q <= full_q + 1'b1;
        2'b01:   full_q <= full_q - 1'b1;
        default: full_q <= full_q;
      endcase
      if (viol) err_q <= 1'b1;
      rd_valid_s1 <= rd_ok;
      if (rd_ok) rd_data_s1 <= mem[rd_bank_q][bus.rd_addr];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] rd_data_s2;
      logic              rd_valid_s2;
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_valid_s2 <= 1'b0;
          rd_data_s2  <= '0;
        end else begin
          rd_valid_s2 <= rd_valid_s1;
          if (rd_valid_s1) rd_data_s2 <= rd_data_s1;
        end
      end
      assign bus.rd_data  = rd_data_s2;
      assign bus.rd_valid = rd_valid_s2;
    end else begin : g_no_out_reg
      assign bus.rd_data  = rd_data_s1;
      assign bus.rd_valid = rd_valid_s1;
    end
  endgenerate

  assign bus.wr_ready = wr_ready;
  assign bus.rd_avail = rd_avail;
  assign bus.wr_bank  = wr_bank_q;
  assign bus.rd_bank  = rd_bank_q;
  assign bus.full_cnt = full_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_multibank_pingpong_ram.sv
// Bench for multibank_pingpong_ram: three instances (2 banks/OUT_REG=1, 2 banks/OUT_REG=0,
// 3 banks/OUT_REG=1) share one stimulus stream; a reference model plus a read scoreboard checks each.
module tb_multibank_pingpong_ram;
  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, wr_commit, rd_en, rd_release;
  logic [2:0]  wr_addr, rd_addr;
  logic [7:0]  wr_be;
  logic [63:0] wr_data;

  always #5 clk = ~clk;

  multibank_pingpong_ram_if #(.DATA_W(64), .DEPTH(8), .NUM_BANKS(2)) if0 ();
  multibank_pingpong_ram_if #(.DATA_W(64), .DEPTH(8), .NUM_BANKS(2)) if1 ();
  multibank_pingpong_ram_if #(.DATA_W(64), .DEPTH(8), .NUM_BANKS(3)) if2 ();

  multibank_pingpong_ram #(.DATA_W(64), .DEPTH(8), .NUM_BANKS(2), .OUT_REG(1))
    dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  multibank_pingpong_ram #(.DATA_W(64), .DEPTH(8), .NUM_BANKS(2), .OUT_REG(0))
    dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  multibank_pingpong_ram #(.DATA_W(64), .DEPTH(8), .NUM_BANKS(3), .OUT_REG(1))
    dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

  assign if0.wr_en = wr_en;  assign if0.wr_addr = wr_addr;  assign if0.wr_be = wr_be;
  assign if0.wr_data = wr_data;  assign if0.wr_commit = wr_commit;  assign if0.rd_en = rd_en;
  assign if0.rd_addr = rd_addr;  assign if0.rd_release = rd_release;
  assign if1.wr_en = wr_en;  assign if1.wr_addr = wr_addr;  assign if1.wr_be = wr_be;
  assign if1.wr_data = wr_data;  assign if1.wr_commit = wr_commit;  assign if1.rd_en = rd_en;
  assign if1.rd_addr = rd_addr;  assign if1.rd_release = rd_release;
  assign if2.wr_en = wr_en;  assign if2.wr_addr = wr_addr;  assign if2.wr_be = wr_be;
  assign if2.wr_data = wr_data;  assign if2.wr_commit = wr_commit;  assign if2.rd_en = rd_en;
  assign if2.rd_addr = rd_addr;  assign if2.rd_release = rd_release;

  logic [63:0] o_data[3], o_full[3], o_wb[3], o_rb[3];
  logic        o_valid[3], o_err[3], o_wrdy[3], o_ravl[3];

  assign o_data[0] = if0.rd_data;  assign o_full[0] = 64'(if0.full_cnt);
  assign o_wb[0] = 64'(if0.wr_bank);  assign o_rb[0] = 64'(if0.rd_bank);
  assign o_valid[0] = if0.rd_valid;  assign o_err[0] = if0.err;
  assign o_wrdy[0] = if0.wr_ready;  assign o_ravl[0] = if0.rd_avail;
  assign o_data[1] = if1.rd_data;  assign o_full[1] = 64'(if1.full_cnt);
  assign o_wb[1] = 64'(if1.wr_bank);  assign o_rb[1] = 64'(if1.rd_bank);
  assign o_valid[1] = if1.rd_valid;  assign o_err[1] = if1.err;
  assign o_wrdy[1] = if1.wr_ready;  assign o_ravl[1] = if1.rd_avail;
  assign o_data[2] = if2.rd_data;  assign o_full[2] = 64'(if2.full_cnt);
  assign o_wb[2] = 64'(if2.wr_bank);  assign o_rb[2] = 64'(if2.rd_bank);
  assign o_valid[2] = if2.rd_valid;  assign o_err[2] = if2.err;
  assign o_wrdy[2] = if2.wr_ready;  assign o_ravl[2] = if2.rd_avail;

  // Reference model state per instance; mknown tracks which bytes have ever been written.
  int          nbk[3] = '{2, 2, 3};
  int          lat[3] = '{2, 1, 2};
  int          mfull[3], mwb[3], mrb[3];
  logic        merr[3];
  logic [63:0] mmem[3][24];
  logic [7:0]  mknown[3][24];
  logic [63:0] mlast[3];
  logic [7:0]  mlastk[3];

  typedef struct {
    int          d;
    logic [63:0] data;
    logic [7:0]  known;
    int          issue;
  } exp_t;
  exp_t sbq[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic string tg(input string s, input int d);
    return $sformatf("%s_dut%0d", s, d);
  endfunction

  function automatic logic [63:0] bmask(input logic [7:0] k);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{k[b]}};
    return m;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      logic rdy, av, c, r;
      int   idx;
      if (reset) begin
        mfull[d] = 0; mwb[d] = 0; mrb[d] = 0; merr[d] = 1'b0;
        mlast[d] = '0; mlastk[d] = 8'hFF;
      end else begin
        rdy = (mfull[d] < nbk[d]);
        av  = (mfull[d] != 0);
        if (((wr_en || wr_commit) && !rdy) || ((rd_en || rd_release) && !av)) merr[d] = 1'b1;
        if (wr_en && rdy) begin
          idx = mwb[d] * 8 + int'(wr_addr);
          for (int b = 0; b < 8; b++) begin
            if (wr_be[b]) begin
              mmem[d][idx][8*b +: 8] = wr_data[8*b +: 8];
              mknown[d][idx][b] = 1'b1;
            end
          end
        end
        if (rd_en && av) begin
          idx = mrb[d] * 8 + int'(rd_addr);
          sbq.push_back('{d, mmem[d][idx], mknown[d][idx], cyc});
        end
        c = wr_commit && rdy;
        r = rd_release && av;
        if (c) mwb[d] = (mwb[d] + 1) % nbk[d];
        if (r) mrb[d] = (mrb[d] + 1) % nbk[d];
        mfull[d] = mfull[d] + int'(c) - int'(r);
      end
    end
    if (reset) sbq.delete();
  endtask

  task automatic compare_all();
    for (int d = 0; d < 3; d++) begin
      int          hit;
      logic [63:0] m;
      hit = -1;
      for (int i = 0; i < sbq.size(); i++) begin
        if (sbq[i].d == d) begin
          hit = i;
          break;
        end
      end
      if (o_valid[d] === 1'b1) begin
        if (hit < 0) begin
          check(tg("rd_valid_unexpected", d), 64'(o_valid[d]), 64'd0);
        end else begin
          m = bmask(sbq[hit].known);
          check(tg("rd_data", d), o_data[d] & m, sbq[hit].data & m);
          check(tg("rd_latency", d), 64'(cyc - sbq[hit].issue), 64'(lat[d]));
          mlast[d]  = sbq[hit].data;
          mlastk[d] = sbq[hit].known;
          sbq.delete(hit);
        end
      end else begin
        m = bmask(mlastk[d]);
        check(tg("rd_data_hold", d), o_data[d] & m, mlast[d] & m);
        if (hit >= 0 && sbq[hit].issue + lat[d] <= cyc) begin
          check(tg("rd_valid_missing", d), 64'(o_valid[d]), 64'd1);
          sbq.delete(hit);
        end
      end
      check(tg("full_cnt", d), o_full[d], 64'(mfull[d]));
      check(tg("wr_bank", d), o_wb[d], 64'(mwb[d]));
      check(tg("rd_bank", d), o_rb[d], 64'(mrb[d]));
      check(tg("err", d), 64'(o_err[d]), 64'(merr[d]));
      check(tg("wr_ready", d), 64'(o_wrdy[d]), 64'(mfull[d] < nbk[d]));
      check(tg("rd_avail", d), 64'(o_ravl[d]), 64'(mfull[d] != 0));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic op(input logic we, input logic [2:0] wa, input logic [7:0] be,
                    input logic [63:0] wd, input logic wc, input logic re,
                    input logic [2:0] ra, input logic rr);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; wr_commit = wc;
    rd_en = re; rd_addr = ra; rd_release = rr;
    tick();
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0; wr_commit = 1'b0;
    rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] be, input logic [63:0] d,
                    input logic c);
    op(1'b1, a, be, d, c, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic rd(input logic [2:0] a, input logic rel);
    op(1'b0, 3'd0, 8'h00, 64'd0, 1'b0, 1'b1, a, rel);
  endtask

  task automatic ctl(input logic c, input logic r);
    op(1'b0, 3'd0, 8'h00, 64'd0, c, 1'b0, 3'd0, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) ctl(1'b0, 1'b0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 24; i++) begin
        mmem[d][i] = '0;
        mknown[d][i] = '0;
      end
      mlast[d] = '0; mlastk[d] = 8'hFF;
      mfull[d] = 0; mwb[d] = 0; mrb[d] = 0; merr[d] = 1'b0;
    end
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0; wr_commit = 1'b0;
    rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;

    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    check("reset_full_cnt", o_full[0], 64'd0);
    check("reset_rd_data", o_data[0], 64'd0);
    idle(1);

    // Fill bank 0 and commit it.
    for (int k = 0; k < 8; k++) wr(3'(k), 8'hFF, 64'h0101_0101_0101_0101 * 64'(k + 1), 1'b0);
    ctl(1'b1, 1'b0);
    check("fill_full_cnt", o_full[0], 64'd1);
    check("fill_wr_bank", o_wb[0], 64'd1);
    check("fill_rd_avail", 64'(o_ravl[0]), 64'd1);

    // Back-to-back reads of bank 0; latency differs per instance.
    for (int k = 0; k < 8; k++) rd(3'(k), 1'b0);
    idle(3);
    check("burst_last_row", o_data[1], 64'h0808_0808_0808_0808);

    // Byte enables in bank 1, then release bank 0 and commit bank 1 with a same-cycle write.
    wr(3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wr(3'd3, 8'h0F, 64'd0, 1'b0);
    wr(3'd3, 8'h00, 64'd0, 1'b0);
    ctl(1'b0, 1'b1);
    wr(3'd4, 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1);
    rd(3'd4, 1'b0);
    rd(3'd3, 1'b0);
    idle(3);
    check("byte_en_row3", o_data[0], 64'hFFFF_FFFF_0000_0000);
    check("byte_en_row3_lat1", o_data[1], 64'hFFFF_FFFF_0000_0000);
    check("byte_en_no_err", 64'(o_err[0]), 64'd0);

    // Commit and release together at full_cnt=1.
    ctl(1'b1, 1'b1);
    check("cr_full_cnt", o_full[0], 64'd1);
    check("cr_wr_bank", o_wb[0], 64'd1);
    check("cr_rd_bank", o_rb[0], 64'd0);
    check("cr_wrap_wr_bank_nb3", o_wb[2], 64'd0);
    check("cr_rd_bank_nb3", o_rb[2], 64'd2);

    // Fill to NUM_BANKS on the 2-bank instances, then an illegal write.
    ctl(1'b1, 1'b0);
    check("full_wr_ready", 64'(o_wrdy[0]), 64'd0);
    check("full_full_cnt", o_full[0], 64'd2);
    check("full_wr_ready_nb3", 64'(o_wrdy[2]), 64'd1);
    wr(3'd0, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    check("overflow_err", 64'(o_err[0]), 64'd1);
    check("overflow_err_nb3", 64'(o_err[2]), 64'd0);
    rd(3'd0, 1'b1);
    idle(3);
    check("overflow_mem_unchanged", o_data[0], 64'h0101_0101_0101_0101);
    ctl(1'b1, 1'b0);
    check("pre_reset_full_cnt", o_full[0], 64'd2);

    // Reset in the middle of a read burst.
    rd(3'd0, 1'b0);
    rd(3'd1, 1'b0);
    reset = 1'b1;
    rd(3'd2, 1'b0);
    reset = 1'b0;
    check("midreset_rd_valid", 64'(o_valid[0]), 64'd0);
    check("midreset_full_cnt", o_full[0], 64'd0);
    check("midreset_err", 64'(o_err[0]), 64'd0);
    idle(3);

    // Release and read with nothing committed.
    ctl(1'b0, 1'b1);
    check("underflow_release_err", 64'(o_err[1]), 64'd1);
    rd(3'd0, 1'b0);
    idle(3);
    check("underflow_full_cnt", o_full[2], 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
